// File: rtl/mul8x8_ha_pkg.sv
// Shared widths and row-weighting helper for the 8x8 half-adder array multiplier.
package mul8x8_ha_pkg;

  localparam int HA_B_W = 7;
  localparam int HA_T_W = 9;
  localparam int ROW_W  = 10;
  localparam int PAIR_W = 12;
  localparam int PROD_W = 16;
  localparam int N_ROWS = 4;

  // t[i] weighs 2^i and b[i] weighs 2^(i+1), so a row is t + 2*b (max 765).
  function automatic logic [ROW_W-1:0] ha_row_value(input logic [HA_B_W-1:0] b,
                                                    input logic [HA_T_W-1:0] t);
    return ROW_W'(t) + (ROW_W'(b) << 1);
  endfunction

endpackage

// File: rtl/ha_row_pair_sum.sv
// Combines two adjacent array rows; the upper row sits two bit positions higher.
module ha_row_pair_sum
  import mul8x8_ha_pkg::*;
(
  input  logic [HA_B_W-1:0] lo_b,
  input  logic [HA_T_W-1:0] lo_t,
  input  logic [HA_B_W-1:0] hi_b,
  input  logic [HA_T_W-1:0] hi_t,
  output logic [PAIR_W-1:0] pair_sum
);

  logic [ROW_W-1:0] row_lo;
  logic [ROW_W-1:0] row_hi;

  assign row_lo = ha_row_value(lo_b, lo_t);
  assign row_hi = ha_row_value(hi_b, hi_t);

  // 765 + 4*765 = 3825 fits in PAIR_W bits.
  assign pair_sum = PAIR_W'(row_lo) + (PAIR_W'(row_hi) << 2);

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_reduce_pipe.sv
// Two-stage elastic reduction of the four half-adder row pairs into the 16-bit product,
// with a wrapping count of delivered products.
module unsigned_mul_8x8_ha_array_reduce_pipe
  import mul8x8_ha_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HA_B_W-1:0] ha_array_0_b,
  input  logic [HA_B_W-1:0] ha_array_1_b,
  input  logic [HA_B_W-1:0] ha_array_2_b,
  input  logic [HA_B_W-1:0] ha_array_3_b,
  input  logic [HA_T_W-1:0] ha_array_0_t,
  input  logic [HA_T_W-1:0] ha_array_1_t,
  input  logic [HA_T_W-1:0] ha_array_2_t,
  input  logic [HA_T_W-1:0] ha_array_3_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic [CNT_W-1:0]  prod_count
);

  localparam int N_PAIRS = N_ROWS / 2;

  logic [HA_B_W-1:0] b_rows [N_ROWS];
  logic [HA_T_W-1:0] t_rows [N_ROWS];

  assign b_rows[0] = ha_array_0_b;
  assign b_rows[1] = ha_array_1_b;
  assign b_rows[2] = ha_array_2_b;
  assign b_rows[3] = ha_array_3_b;
  assign t_rows[0] = ha_array_0_t;
  assign t_rows[1] = ha_array_1_t;
  assign t_rows[2] = ha_array_2_t;
  assign t_rows[3] = ha_array_3_t;

  logic [PAIR_W-1:0] pair_d [N_PAIRS];
  logic [PAIR_W-1:0] pair_q [N_PAIRS];
  logic              v1_q;
  logic              v2_q;
  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] prod_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              en1;
  logic              en2;

  genvar gi;
  generate
    for (gi = 0; gi < N_PAIRS; gi++) begin : g_pair
      ha_row_pair_sum u_pair (
        .lo_b     (b_rows[2*gi]),
        .lo_t     (t_rows[2*gi]),
        .hi_b     (b_rows[2*gi+1]),
        .hi_t     (t_rows[2*gi+1]),
        .pair_sum (pair_d[gi])
      );
    end
  endgenerate

  // Stage 2 may advance whenever it is empty or being drained; stage 1 follows it.
  assign en2      = !v2_q || out_ready;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  // Upper pair carries row weights 4^2 relative to the lower pair; max 65025 fits 16 bits.
  assign prod_d = PROD_W'(pair_q[0]) + (PROD_W'(pair_q[1]) << 4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      for (int i = 0; i < N_PAIRS; i++) begin
        pair_q[i] <= '0;
      end
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < N_PAIRS; i++) begin
          pair_q[i] <= pair_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      prod_q <= '0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        prod_q <= prod_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (v2_q && out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = v2_q;
  assign product    = prod_q;
  assign prod_count = cnt_q;

endmodule
